// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: multi-cycle load-use bubbles,
// memory freeze with timeout trap. Optional statistics counters: HAZ_STATS_EN.
module pipeline_hazard_ctrl #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int MEM_TIMEOUT      = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ID_EX_MemRead_i,
    input  logic [4:0]  ID_EX_Rt_i,
    input  logic [4:0]  IF_ID_Rs_i,
    input  logic [4:0]  IF_ID_Rt_i,
    input  logic        Branch_taken_i,
    input  logic        dmem_stall_i,
    output logic        PCWrite_o,
    output logic        IF_IDWrite_o,
    output logic        IF_IDFlush_o,
    output logic        ctrl_sel_o,
    output logic        Pipe_en_o,
    output logic        error_o,
    output logic [15:0] lu_stall_cnt_o,
    output logic [15:0] mem_stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    localparam logic [2:0] LP_BUB_LAST = 3'(LOAD_USE_BUBBLES - 1);
    localparam logic [9:0] LP_TO_LAST  = 10'(MEM_TIMEOUT - 1);
    localparam bit         LP_MULTI    = (LOAD_USE_BUBBLES > 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_bub_cnt;
    logic [2:0]  w_bub_cnt_nxt;
    logic [9:0]  r_to_cnt;
    logic [9:0]  w_to_cnt_nxt;
    logic        w_lu;
    logic        w_pc_we;
    logic        w_ifid_we;
    logic        w_ifid_flush;
    logic        w_ctrl_sel;
    logic        w_pipe_en;
    logic        w_error;

    // Load-use hazard: load in EX writes a register read by the instruction in ID.
    function automatic logic lu_hazard(input logic       mem_rd,
                                       input logic [4:0] ex_rt,
                                       input logic [4:0] id_rs,
                                       input logic [4:0] id_rt);
        return mem_rd && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

    assign w_lu = lu_hazard(ID_EX_MemRead_i, ID_EX_Rt_i, IF_ID_Rs_i, IF_ID_Rt_i);

    // State, bubble counter and memory-timeout counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= ST_RUN;
            r_bub_cnt <= 3'd0;
            r_to_cnt  <= 10'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_bub_cnt <= w_bub_cnt_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
        end
    end

    // Next-state and Mealy output decode; reset forces the idle RUN decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_bub_cnt_nxt = r_bub_cnt;
        w_to_cnt_nxt  = 10'd0;
        w_pc_we       = 1'b1;
        w_ifid_we     = 1'b1;
        w_ifid_flush  = 1'b0;
        w_ctrl_sel    = 1'b1;
        w_pipe_en     = 1'b1;
        w_error       = 1'b0;
        if (!rst_i) begin
            w_state_nxt   = ST_RUN;
            w_bub_cnt_nxt = 3'd0;
        end else begin
            case (r_state)
                ST_RUN, ST_LU_STALL: begin
                    if (dmem_stall_i) begin
                        w_pc_we      = 1'b0;
                        w_ifid_we    = 1'b0;
                        w_pipe_en    = 1'b0;
                        w_to_cnt_nxt = r_to_cnt + 10'd1;
                        if (r_to_cnt == LP_TO_LAST) begin
                            w_state_nxt = ST_ERROR;
                        end else begin
                            w_state_nxt = r_state;
                        end
                    end else if (r_state == ST_LU_STALL) begin
                        // Instruction in ID is stale here, so lu and branch are ignored.
                        w_pc_we    = 1'b0;
                        w_ifid_we  = 1'b0;
                        w_ctrl_sel = 1'b0;
                        if (r_bub_cnt == LP_BUB_LAST) begin
                            w_state_nxt   = ST_RUN;
                            w_bub_cnt_nxt = 3'd0;
                        end else begin
                            w_bub_cnt_nxt = r_bub_cnt + 3'd1;
                        end
                    end else if (w_lu) begin
                        w_pc_we    = 1'b0;
                        w_ifid_we  = 1'b0;
                        w_ctrl_sel = 1'b0;
                        if (LP_MULTI) begin
                            w_state_nxt   = ST_LU_STALL;
                            w_bub_cnt_nxt = 3'd1;
                        end else begin
                            w_state_nxt = ST_RUN;
                        end
                    end else if (Branch_taken_i) begin
                        w_ifid_flush = 1'b1;
                    end else begin
                        w_ifid_flush = 1'b0;
                    end
                end
                ST_ERROR: begin
                    w_pc_we     = 1'b0;
                    w_ifid_we   = 1'b0;
                    w_pipe_en   = 1'b0;
                    w_ctrl_sel  = 1'b0;
                    w_error     = 1'b1;
                    w_state_nxt = ST_ERROR;
                end
                default: begin
                    // An unreachable encoding is treated as a fault and parks the pipe.
                    w_pc_we     = 1'b0;
                    w_ifid_we   = 1'b0;
                    w_pipe_en   = 1'b0;
                    w_ctrl_sel  = 1'b0;
                    w_error     = 1'b1;
                    w_state_nxt = ST_ERROR;
                end
            endcase
        end
    end

    assign PCWrite_o    = w_pc_we;
    assign IF_IDWrite_o = w_ifid_we;
    assign IF_IDFlush_o = w_ifid_flush;
    assign ctrl_sel_o   = w_ctrl_sel;
    assign Pipe_en_o    = w_pipe_en;
    assign error_o      = w_error;

`ifdef HAZ_STATS_EN
    logic        w_run_like;
    logic        w_freeze;
    logic        w_lu_bubble;
    logic [15:0] r_lu_stall_cnt;
    logic [15:0] r_mem_stall_cnt;

    assign w_run_like  = rst_i && ((r_state == ST_RUN) || (r_state == ST_LU_STALL));
    assign w_freeze    = w_run_like && dmem_stall_i;
    assign w_lu_bubble = w_run_like && !dmem_stall_i && !w_ctrl_sel;

    // Saturating statistics counters, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_lu_stall_cnt  <= 16'd0;
            r_mem_stall_cnt <= 16'd0;
        end else begin
            if (w_lu_bubble && (r_lu_stall_cnt != 16'hFFFF)) begin
                r_lu_stall_cnt <= r_lu_stall_cnt + 16'd1;
            end else begin
                r_lu_stall_cnt <= r_lu_stall_cnt;
            end
            if (w_freeze && (r_mem_stall_cnt != 16'hFFFF)) begin
                r_mem_stall_cnt <= r_mem_stall_cnt + 16'd1;
            end else begin
                r_mem_stall_cnt <= r_mem_stall_cnt;
            end
        end
    end

    assign lu_stall_cnt_o  = r_lu_stall_cnt;
    assign mem_stall_cnt_o = r_mem_stall_cnt;
`else
    assign lu_stall_cnt_o  = 16'd0;
    assign mem_stall_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two configurations driven in lock-step and
// checked each cycle against a bubble/timeout bookkeeping model.
module tb_pipeline_hazard_ctrl;
    localparam int BUB_A = 1;
    localparam int TO_A  = 4;
    localparam int BUB_B = 3;
    localparam int TO_B  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       memrd;
    logic [4:0] ex_rt;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       br;
    logic       dmem;

    logic        a_pcw, a_ifw, a_fl, a_cs, a_pe, a_err;
    logic [15:0] a_luc, a_msc;
    logic        b_pcw, b_ifw, b_fl, b_cs, b_pe, b_err;
    logic [15:0] b_luc, b_msc;

    int m_bub_left[2];
    int m_run[2];
    bit m_err[2];
    int m_lu_cnt[2];
    int m_ms_cnt[2];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.LOAD_USE_BUBBLES(BUB_A), .MEM_TIMEOUT(TO_A)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .ID_EX_MemRead_i(memrd), .ID_EX_Rt_i(ex_rt),
        .IF_ID_Rs_i(id_rs), .IF_ID_Rt_i(id_rt), .Branch_taken_i(br), .dmem_stall_i(dmem),
        .PCWrite_o(a_pcw), .IF_IDWrite_o(a_ifw), .IF_IDFlush_o(a_fl), .ctrl_sel_o(a_cs),
        .Pipe_en_o(a_pe), .error_o(a_err), .lu_stall_cnt_o(a_luc), .mem_stall_cnt_o(a_msc)
    );

    pipeline_hazard_ctrl #(.LOAD_USE_BUBBLES(BUB_B), .MEM_TIMEOUT(TO_B)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .ID_EX_MemRead_i(memrd), .ID_EX_Rt_i(ex_rt),
        .IF_ID_Rs_i(id_rs), .IF_ID_Rt_i(id_rt), .Branch_taken_i(br), .dmem_stall_i(dmem),
        .PCWrite_o(b_pcw), .IF_IDWrite_o(b_ifw), .IF_IDFlush_o(b_fl), .ctrl_sel_o(b_cs),
        .Pipe_en_o(b_pe), .error_o(b_err), .lu_stall_cnt_o(b_luc), .mem_stall_cnt_o(b_msc)
    );

    function automatic int bub_of(input int k);
        return (k == 0) ? BUB_A : BUB_B;
    endfunction

    function automatic int to_of(input int k);
        return (k == 0) ? TO_A : TO_B;
    endfunction

    function automatic bit lu_now();
        return memrd && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

    // Expected {PCWrite, IF_IDWrite, IF_IDFlush, ctrl_sel, Pipe_en, error}.
    function automatic logic [5:0] exp_out(input int k);
        if (!rst)                             return 6'b110110;
        else if (m_err[k])                    return 6'b000001;
        else if (dmem)                        return 6'b000100;
        else if (m_bub_left[k] > 0 || lu_now()) return 6'b000010;
        else if (br)                          return 6'b111110;
        else                                  return 6'b110110;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_bub_left[k] = 0;
            m_run[k]      = 0;
            m_err[k]      = 1'b0;
            m_lu_cnt[k]   = 0;
            m_ms_cnt[k]   = 0;
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (!rst || m_err[k]) begin
                continue;
            end
            if (dmem) begin
                m_run[k]++;
                if (m_ms_cnt[k] < 65535) m_ms_cnt[k]++;
                if (m_run[k] >= to_of(k)) m_err[k] = 1'b1;
            end else begin
                m_run[k] = 0;
                if (m_bub_left[k] > 0) begin
                    m_bub_left[k]--;
                    if (m_lu_cnt[k] < 65535) m_lu_cnt[k]++;
                end else if (lu_now()) begin
                    m_bub_left[k] = bub_of(k) - 1;
                    if (m_lu_cnt[k] < 65535) m_lu_cnt[k]++;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [5:0]  act_o[2];
        logic [31:0] act_c[2];
        logic [5:0]  exp_o;
        logic [31:0] exp_c;
        act_o[0] = {a_pcw, a_ifw, a_fl, a_cs, a_pe, a_err};
        act_o[1] = {b_pcw, b_ifw, b_fl, b_cs, b_pe, b_err};
        act_c[0] = {a_luc, a_msc};
        act_c[1] = {b_luc, b_msc};
        for (int k = 0; k < 2; k++) begin
            exp_o = exp_out(k);
`ifdef HAZ_STATS_EN
            exp_c = {16'(m_lu_cnt[k]), 16'(m_ms_cnt[k])};
`else
            exp_c = 32'd0;
`endif
            n_tests++;
            assert (act_o[k] === exp_o) else begin
                n_fail++;
                $error("FAIL %s_out%0d t=%0t observed=%b expected=%b", tag, k, $time, act_o[k], exp_o);
            end
            n_tests++;
            assert (act_c[k] === exp_c) else begin
                n_fail++;
                $error("FAIL %s_cnt%0d t=%0t observed=%h expected=%h", tag, k, $time, act_c[k], exp_c);
            end
        end
    endtask

    task automatic step(input string tag, input logic r, input logic m, input logic [4:0] ert,
                        input logic [4:0] rs, input logic [4:0] rt2, input logic b, input logic d);
        @(negedge clk);
        rst = r; memrd = m; ex_rt = ert; id_rs = rs; id_rt = rt2; br = b; dmem = d;
        #1;
        if (!rst) model_reset();
        check_all(tag);
        @(posedge clk);
        model_update();
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        int burst;
        logic r_v, d_v;
        rst = 1'b0; memrd = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd0; br = 1'b1; dmem = 1'b0;
        model_reset();
        step("rst_hold", 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1);
        idle("idle", 2);
        step("lu_pulse", 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
        idle("lu_after", 4);
        step("lu_rt0", 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step("lu_rt_match", 1'b1, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0);
        idle("lu_after2", 3);
        step("lu_frz_c1", 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
        step("lu_frz_c2", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        idle("lu_frz_c3", 3);
        step("lu_br", 1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0);
        step("lu_br_stale", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        idle("lu_br_after", 2);
        step("br_alone", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        idle("br_after", 1);
        for (int i = 0; i < 3; i++) step("frz3", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        idle("frz3_after", 2);
        for (int i = 0; i < 4; i++) step("frz4", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        step("err_hold", 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        idle("err_sticky", 3);
        step("err_rst", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        idle("post_rst", 1);
        // Reset in the middle of a multi-cycle bubble sequence.
        step("midstall_lu", 1'b1, 1'b1, 5'd3, 5'd0, 5'd3, 1'b0, 1'b0);
        step("midstall_rst", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        idle("midstall_after", 2);
        // Stats: two hazards and five freeze cycles.
        step("st_lu1", 1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0);
        idle("st_gap1", 3);
        for (int i = 0; i < 5; i++) step("st_frz", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        idle("st_gap2", 1);
        step("st_lu2", 1'b1, 1'b1, 5'd6, 5'd0, 5'd6, 1'b0, 1'b0);
        idle("st_end", 3);
        step("rnd_rst", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        burst = 0;
        for (int i = 0; i < 800; i++) begin
            r_v = ($urandom_range(0, 59) != 0);
            if (burst > 0) begin
                d_v = 1'b1;
                burst--;
            end else if ($urandom_range(0, 29) == 0) begin
                burst = $urandom_range(2, 10);
                d_v = 1'b1;
            end else begin
                d_v = ($urandom_range(0, 4) == 0);
            end
            step("rnd", r_v, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0), d_v);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
